mod_99_8b: RTL and testbench

MOD_99_8B -- requirements
Module: mod_99_8b

---
 rtl/mod_99_8b_if.sv | 22 ++
 rtl/mod_99_8b.sv | 115 +++++++++++
 tb/tb_mod_99_8b.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mod_99_8b_if.sv
// Respond handshake between the respond FSM and the MAC receive/transmit processes.
// master = respond FSM (issues send_r/rcv_v_clr), slave = receive/transmit side.
interface mod_99_8b_if;
  logic rcv_v;
  logic rcv_v_clr;
  logic send_r;
  logic r_sent;

  modport master (
    input  rcv_v,
    input  r_sent,
    output send_r,
    output rcv_v_clr
  );

  modport slave (
    output rcv_v,
    output r_sent,
    input  send_r,
    input  rcv_v_clr
  );
endinterface

// File: rtl/mod_99_8b.sv
// Preemption verify/respond FSM: answers each received verify with one respond mPacket.
// All outputs registered (one-cycle latency); a verify arriving mid-respond is queued as pending.
module mod_99_8b #(
  parameter int RESP_TIMEOUT = 1000,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_begin,
  input  logic             link_fail,
  input  logic             pEnable,
  mod_99_8b_if.master      resp_if,
  output logic [1:0]       mod_99_8b_state,
  output logic             respond_pending,
  output logic             resp_err,
  output logic [CNT_W-1:0] respondCnt
);

  localparam int TW = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    INIT_RESPONSE = 2'b00,
    RESPONSE_IDLE = 2'b01,
    SEND_RESPOND  = 2'b10
  } state_t;

  state_t            state_q, state_nxt;
  logic [TW-1:0]     timer_q, timer_nxt;
  logic              send_q, send_nxt;
  logic              clr_q, clr_nxt;
  logic              pend_nxt;
  logic              err_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    send_nxt  = 1'b0;
    clr_nxt   = 1'b0;
    pend_nxt  = respond_pending;
    err_nxt   = 1'b0;
    cnt_nxt   = respondCnt;

    if (link_fail || !pEnable) begin
      state_nxt = INIT_RESPONSE;
      pend_nxt  = 1'b0;
      timer_nxt = '0;
    end else begin
      case (state_q)
        INIT_RESPONSE: state_nxt = RESPONSE_IDLE;

        RESPONSE_IDLE: begin
          if (resp_if.rcv_v || respond_pending) begin
            state_nxt = SEND_RESPOND;
            send_nxt  = 1'b1;
            clr_nxt   = 1'b1;
            pend_nxt  = 1'b0;
            timer_nxt = '0;
            if (respondCnt != '1)
              cnt_nxt = respondCnt + CNT_W'(1);
          end
        end

        SEND_RESPOND: begin
          if (resp_if.r_sent) begin
            state_nxt = RESPONSE_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            state_nxt = RESPONSE_IDLE;
            err_nxt   = 1'b1;
          end else begin
            send_nxt  = 1'b1;
            timer_nxt = timer_q + TW'(1);
          end
          // rcv_v is still high in the entry cycle from the verify being served; the
          // pending/clr guards keep one new verify from producing more than one clear.
          if (resp_if.rcv_v && (timer_q != '0) && !respond_pending && !clr_q) begin
            pend_nxt = 1'b1;
            clr_nxt  = 1'b1;
          end
        end

        default: begin
          state_nxt = INIT_RESPONSE;
          pend_nxt  = 1'b0;
          timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_begin) begin
      state_q         <= INIT_RESPONSE;
      timer_q         <= '0;
      send_q          <= 1'b0;
      clr_q           <= 1'b0;
      respond_pending <= 1'b0;
      resp_err        <= 1'b0;
      respondCnt      <= '0;
    end else begin
      state_q         <= state_nxt;
      timer_q         <= timer_nxt;
      send_q          <= send_nxt;
      clr_q           <= clr_nxt;
      respond_pending <= pend_nxt;
      resp_err        <= err_nxt;
      respondCnt      <= cnt_nxt;
    end
  end

  assign mod_99_8b_state   = state_q;
  assign resp_if.send_r    = send_q;
  assign resp_if.rcv_v_clr = clr_q;

endmodule

// File: tb/tb_mod_99_8b.sv
// Directed bench: dut_a (long timeout, 8-bit count) and dut_b (timeout 4, 2-bit count) share stimulus.
module tb_mod_99_8b;
  logic clk;
  logic reset_begin;
  logic link_fail;
  logic pEnable;

  logic [1:0] st_a, st_b;
  logic       pend_a, pend_b;
  logic       err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  mod_99_8b_if ifa ();
  mod_99_8b_if ifb ();

  mod_99_8b #(.RESP_TIMEOUT(16), .CNT_W(8)) dut_a (
    .clk(clk), .reset_begin(reset_begin), .link_fail(link_fail), .pEnable(pEnable),
    .resp_if(ifa), .mod_99_8b_state(st_a), .respond_pending(pend_a),
    .resp_err(err_a), .respondCnt(cnt_a)
  );

  mod_99_8b #(.RESP_TIMEOUT(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_begin(reset_begin), .link_fail(link_fail), .pEnable(pEnable),
    .resp_if(ifb), .mod_99_8b_state(st_b), .respond_pending(pend_b),
    .resp_err(err_b), .respondCnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int clr_cnt_a = 0;
  int err_cnt_b = 0;

  task automatic chk_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock; the receive model drops rcv_v at the edge that sees rcv_v_clr.
  task automatic tick();
    logic ca, cb;
    ca = ifa.rcv_v_clr;
    cb = ifb.rcv_v_clr;
    @(posedge clk);
    #1;
    if (ca) ifa.rcv_v = 1'b0;
    if (cb) ifb.rcv_v = 1'b0;
    cyc++;
    if (ifa.rcv_v_clr) clr_cnt_a++;
    if (err_b) err_cnt_b++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic set_rcv();
    ifa.rcv_v = 1'b1;
    ifb.rcv_v = 1'b1;
  endtask

  task automatic set_sent(input logic v);
    ifa.r_sent = v;
    ifb.r_sent = v;
  endtask

  task automatic do_reset();
    reset_begin = 1'b1;
    link_fail   = 1'b0;
    pEnable     = 1'b1;
    ifa.rcv_v = 1'b0; ifb.rcv_v = 1'b0;
    set_sent(1'b0);
    tick();
    tick();
    reset_begin = 1'b0;
    cyc = 0;
  endtask

  initial begin
    reset_begin = 1'b1;
    link_fail = 1'b0;
    pEnable = 1'b0;
    ifa.rcv_v = 1'b0; ifb.rcv_v = 1'b0;
    ifa.r_sent = 1'b0; ifb.r_sent = 1'b0;

    // Basic respond, plus r_sent outside SEND_RESPOND
    do_reset();
    chk_val("rst_state", st_a, 0);
    chk_val("rst_send", ifa.send_r, 0);
    chk_val("rst_clr", ifa.rcv_v_clr, 0);
    chk_val("rst_pend", pend_a, 0);
    chk_val("rst_err", err_a, 0);
    chk_val("rst_cnt", cnt_a, 0);
    run_to(1);
    chk_val("init_to_idle", st_a, 1);
    set_sent(1'b1);
    run_to(2);
    set_sent(1'b0);
    chk_val("idle_ignores_rsent", st_a, 1);
    chk_val("idle_send_low", ifa.send_r, 0);
    run_to(3);
    set_rcv();
    run_to(4);
    chk_val("basic_entry_state", st_a, 2);
    chk_val("basic_entry_send", ifa.send_r, 1);
    chk_val("basic_entry_clr", ifa.rcv_v_clr, 1);
    chk_val("basic_cnt", cnt_a, 1);
    run_to(5);
    chk_val("basic_clr_pulse_end", ifa.rcv_v_clr, 0);
    chk_val("basic_send_held", ifa.send_r, 1);
    run_to(10);
    chk_val("basic_still_send", st_a, 2);
    set_sent(1'b1);
    run_to(11);
    set_sent(1'b0);
    chk_val("basic_exit_state", st_a, 1);
    chk_val("basic_exit_send", ifa.send_r, 0);
    chk_val("basic_no_err", err_a, 0);

    // Pending verify during respond
    do_reset();
    run_to(3);
    set_rcv();
    run_to(4);
    clr_cnt_a = 0;
    run_to(6);
    set_rcv();
    run_to(7);
    chk_val("pend_set", pend_a, 1);
    chk_val("pend_clr", ifa.rcv_v_clr, 1);
    run_to(10);
    set_sent(1'b1);
    run_to(11);
    set_sent(1'b0);
    chk_val("pend_idle_state", st_a, 1);
    chk_val("pend_idle_send", ifa.send_r, 0);
    chk_val("pend_one_clr", clr_cnt_a, 1);
    run_to(12);
    chk_val("pend_reenter", st_a, 2);
    chk_val("pend_cleared", pend_a, 0);
    chk_val("pend_cnt", cnt_a, 2);

    // Timeout on dut_b (RESP_TIMEOUT=4), pending retained through it
    do_reset();
    run_to(3);
    set_rcv();
    run_to(4);
    err_cnt_b = 0;
    run_to(5);
    set_rcv();
    run_to(7);
    chk_val("to_still_send", st_b, 2);
    chk_val("to_no_early_err", err_b, 0);
    run_to(8);
    chk_val("to_exit_state", st_b, 1);
    chk_val("to_err", err_b, 1);
    chk_val("to_send_low", ifb.send_r, 0);
    chk_val("to_pend_kept", pend_b, 1);
    run_to(9);
    chk_val("to_err_once", err_cnt_b, 1);
    chk_val("to_reenter", st_b, 2);

    // r_sent collides with the last timer cycle
    do_reset();
    run_to(3);
    set_rcv();
    run_to(7);
    set_sent(1'b1);
    run_to(8);
    set_sent(1'b0);
    chk_val("coll_state", st_b, 1);
    chk_val("coll_no_err", err_b, 0);

    // Saturation: five completed responds
    do_reset();
    run_to(1);
    for (int i = 1; i <= 5; i++) begin
      set_rcv();
      tick();
      set_sent(1'b1);
      tick();
      set_sent(1'b0);
      chk_val("sat_cnt_b", cnt_b, (i > 3) ? 3 : i);
      chk_val("sat_cnt_a", cnt_a, i);
    end

    // Abort by link_fail / pEnable, then reset mid-respond
    do_reset();
    run_to(3);
    set_rcv();
    run_to(6);
    link_fail = 1'b1;
    run_to(7);
    link_fail = 1'b0;
    chk_val("abort_state", st_a, 0);
    chk_val("abort_send", ifa.send_r, 0);
    chk_val("abort_cnt_kept", cnt_a, 1);
    run_to(8);
    chk_val("abort_recover", st_a, 1);
    pEnable = 1'b0;
    run_to(9);
    pEnable = 1'b1;
    chk_val("penable_low_state", st_a, 0);
    run_to(10);
    set_rcv();
    run_to(11);
    chk_val("abort2_cnt", cnt_a, 2);
    reset_begin = 1'b1;
    run_to(12);
    reset_begin = 1'b0;
    chk_val("midrst_state", st_a, 0);
    chk_val("midrst_send", ifa.send_r, 0);
    chk_val("midrst_cnt", cnt_a, 0);
    run_to(13);
    chk_val("post_rst_idle", st_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
